// File: rtl/pass_done_tracker.sv
// pass_done_tracker
// Consumer of the MTC0 pass/fail/done reports coming out of execute.
// Keeps saturating pass/fail counters, the first failing test code and the
// end-of-test status, and queues every accepted report in a small event FIFO
// that a host drains with a valid/ready handshake.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pass_done_tracker #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rpt_valid,
    input  logic [1:0]             rpt_kind,
    input  logic [`DATA_WIDTH-1:0] rpt_code,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [1:0]             evt_kind,
    output logic [`DATA_WIDTH-1:0] evt_code,
    output logic [CNT_WIDTH-1:0]   pass_count,
    output logic [CNT_WIDTH-1:0]   fail_count,
    output logic [`DATA_WIDTH-1:0] first_fail_code,
    output logic                   first_fail_valid,
    output logic                   done,
    output logic                   passed,
    output logic                   overflow
);

    localparam int DW = `DATA_WIDTH;
    // Address width of the storage; pointers carry one extra wrap bit.
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] KIND_PASS = 2'b01;
    localparam logic [1:0] KIND_FAIL = 2'b10;
    localparam logic [1:0] KIND_DONE = 2'b11;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0]           state_reg;
    logic [CNT_WIDTH-1:0] pass_count_reg;
    logic [CNT_WIDTH-1:0] fail_count_reg;
    logic [DW-1:0]        first_fail_code_reg;
    logic                 first_fail_valid_reg;
    logic                 overflow_reg;
    logic [AW:0]          wr_ptr_reg;
    logic [AW:0]          rd_ptr_reg;

    // Entry layout: {kind, code}. Storage is deliberately not reset; the
    // pointers alone decide which entries are meaningful.
    logic [DW+1:0]        mem [FIFO_DEPTH];

    logic accept;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;

    // A report only counts while running and when it carries a real kind.
    assign accept     = (state_reg == ST_RUN) && rpt_valid && (rpt_kind != 2'b00);
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                        (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign pop        = !fifo_empty && evt_ready;
    // A full FIFO still takes the new entry if the head leaves this cycle.
    assign push       = accept && (!fifo_full || pop);

    // Run/halt control: a DONE report halts until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RUN;
        end else if (accept && rpt_kind == KIND_DONE) begin
            state_reg <= ST_HALTED;
        end
    end

    // Saturating pass/fail counters; they update even when the FIFO drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_count_reg <= '0;
            fail_count_reg <= '0;
        end else if (accept) begin
            if (rpt_kind == KIND_PASS && pass_count_reg != '1) begin
                pass_count_reg <= pass_count_reg + CNT_WIDTH'(1);
            end
            if (rpt_kind == KIND_FAIL && fail_count_reg != '1) begin
                fail_count_reg <= fail_count_reg + CNT_WIDTH'(1);
            end
        end
    end

    // Capture only the very first failing test code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_fail_code_reg  <= '0;
            first_fail_valid_reg <= 1'b0;
        end else if (accept && rpt_kind == KIND_FAIL && !first_fail_valid_reg) begin
            first_fail_code_reg  <= rpt_code;
            first_fail_valid_reg <= 1'b1;
        end
    end

    // Sticky flag for any accepted report that found no room in the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (accept && !push) begin
            overflow_reg <= 1'b1;
        end
    end

    // FIFO pointers advance freely and wrap through the extra bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    // FIFO storage write; no reset so it maps onto plain memory.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= {rpt_kind, rpt_code};
        end
    end

    // Head entry is presented straight from storage and forced to zero when empty.
    always_comb begin
        evt_kind = 2'b00;
        evt_code = '0;
        if (!fifo_empty) begin
            {evt_kind, evt_code} = mem[rd_ptr_reg[AW-1:0]];
        end
    end

    assign evt_valid        = !fifo_empty;
    assign pass_count       = pass_count_reg;
    assign fail_count       = fail_count_reg;
    assign first_fail_code  = first_fail_code_reg;
    assign first_fail_valid = first_fail_valid_reg;
    assign done             = (state_reg == ST_HALTED);
    assign passed           = (state_reg == ST_HALTED) && (fail_count_reg == '0);
    assign overflow         = overflow_reg;

endmodule

// File: tb/tb_pass_done_tracker.sv
// Testbench for pass_done_tracker: directed scenarios followed by random
// traffic, checked against a behavioural model and an event scoreboard.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_pass_done_tracker;

    localparam int DW    = `DATA_WIDTH;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
    localparam int CW2   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rpt_valid = 1'b0;
    logic [1:0]    rpt_kind = 2'b00;
    logic [DW-1:0] rpt_code = '0;
    logic          evt_ready = 1'b0;

    logic          evt_valid;
    logic [1:0]    evt_kind;
    logic [DW-1:0] evt_code;
    logic [CW-1:0] pass_count, fail_count;
    logic [DW-1:0] first_fail_code;
    logic          first_fail_valid, done, passed, overflow;

    // Second instance with tiny counters, fed the same reports, for saturation.
    logic          s_evt_valid;
    logic [1:0]    s_evt_kind;
    logic [DW-1:0] s_evt_code;
    logic [CW2-1:0] s_pass_count, s_fail_count;
    logic [DW-1:0] s_first_fail_code;
    logic          s_first_fail_valid, s_done, s_passed, s_overflow;

    always #5 clk = ~clk;

    pass_done_tracker #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .rpt_valid(rpt_valid), .rpt_kind(rpt_kind), .rpt_code(rpt_code),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_kind(evt_kind), .evt_code(evt_code),
        .pass_count(pass_count), .fail_count(fail_count),
        .first_fail_code(first_fail_code), .first_fail_valid(first_fail_valid),
        .done(done), .passed(passed), .overflow(overflow)
    );

    pass_done_tracker #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW2)) dut_sat (
        .clk(clk), .rst(rst),
        .rpt_valid(rpt_valid), .rpt_kind(rpt_kind), .rpt_code(rpt_code),
        .evt_valid(s_evt_valid), .evt_ready(evt_ready),
        .evt_kind(s_evt_kind), .evt_code(s_evt_code),
        .pass_count(s_pass_count), .fail_count(s_fail_count),
        .first_fail_code(s_first_fail_code), .first_fail_valid(s_first_fail_valid),
        .done(s_done), .passed(s_passed), .overflow(s_overflow)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: plain counts, a flag set, and an occupancy number.
    int            m_pass, m_fail, m_occ;
    logic [DW-1:0] m_ffc;
    bit            m_ffv, m_done, m_ovf;

    typedef struct {
        logic [1:0]    k;
        logic [DW-1:0] c;
    } evt_t;
    evt_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat(input int v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (longint'(v) > m) ? 64'(m) : 64'(v);
    endfunction

    task automatic model_reset();
        m_pass = 0; m_fail = 0; m_occ = 0;
        m_ffc = '0; m_ffv = 0; m_done = 0; m_ovf = 0;
        sb.delete();
    endtask

    task automatic check_all();
        chk("pass_count", 64'(pass_count), sat(m_pass, CW));
        chk("fail_count", 64'(fail_count), sat(m_fail, CW));
        chk("sat_pass_count", 64'(s_pass_count), sat(m_pass, CW2));
        chk("sat_fail_count", 64'(s_fail_count), sat(m_fail, CW2));
        chk("first_fail_valid", 64'(first_fail_valid), 64'(m_ffv));
        chk("first_fail_code", 64'(first_fail_code), 64'(m_ffc));
        chk("done", 64'(done), 64'(m_done));
        chk("passed", 64'(passed), 64'(m_done && m_fail == 0));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("evt_valid", 64'(evt_valid), 64'(m_occ > 0));
        if (m_occ == 0) begin
            chk("idle_evt_kind", 64'(evt_kind), 64'(0));
            chk("idle_evt_code", 64'(evt_code), 64'(0));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pass_count"}, 64'(pass_count), 64'(0));
        chk({tag, "_fail_count"}, 64'(fail_count), 64'(0));
        chk({tag, "_first_fail_code"}, 64'(first_fail_code), 64'(0));
        chk({tag, "_first_fail_valid"}, 64'(first_fail_valid), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_passed"}, 64'(passed), 64'(0));
        chk({tag, "_overflow"}, 64'(overflow), 64'(0));
        chk({tag, "_evt_valid"}, 64'(evt_valid), 64'(0));
        chk({tag, "_evt_kind"}, 64'(evt_kind), 64'(0));
        chk({tag, "_evt_code"}, 64'(evt_code), 64'(0));
    endtask

    // One clock cycle of stimulus; the model decides the outcome from the rules.
    task automatic step(input bit v, input logic [1:0] k, input logic [DW-1:0] c, input bit r);
        bit pop, acc;
        rpt_valid = v; rpt_kind = k; rpt_code = c; evt_ready = r;
        pop = r && (m_occ > 0);
        acc = v && (k != 2'b00) && !m_done;
        if (acc) begin
            if (k == 2'b01) m_pass++;
            else if (k == 2'b10) begin
                m_fail++;
                if (!m_ffv) begin m_ffv = 1; m_ffc = c; end
            end else m_done = 1;
            if (m_occ < DEPTH || pop) begin
                sb.push_back('{k: k, c: c});
                m_occ++;
            end else begin
                m_ovf = 1;
            end
        end
        if (pop) m_occ--;
        $display("step v=%0d kind=%0d code=0x%0h ready=%0d -> occ=%0d pass=%0d fail=%0d done=%0d",
                 v, k, c, r, m_occ, m_pass, m_fail, m_done);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input bit r);
        step(1'b0, 2'b00, '0, r);
    endtask

    // Reset asserted between edges: outputs must clear without a clock.
    task automatic async_reset();
        rpt_valid = 1'b0; rpt_kind = 2'b00; evt_ready = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("async reset applied");
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && m_occ > 0; i++) idle(1'b1);
        chk("drain_sb_empty", 64'(sb.size()), 64'(0));
        chk("drain_evt_valid", 64'(evt_valid), 64'(0));
    endtask

    // Monitor: a handshake seen mid-cycle pops the scoreboard and compares data.
    always @(negedge clk) begin
        evt_t e;
        if (!rst && evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                chk("evt_unexpected", 64'(evt_code), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("evt_kind", 64'(evt_kind), 64'(e.k));
                chk("evt_code", 64'(evt_code), 64'(e.c));
                $display("event kind=%0d code=0x%0h", evt_kind, evt_code);
            end
        end
    end

    initial begin
        model_reset();
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();

        // Basic count with draining.
        step(1, 2'b01, 32'h1, 1);
        step(1, 2'b01, 32'h2, 1);
        step(1, 2'b11, 32'h0, 1);
        drain();
        async_reset();

        // First fail capture.
        step(1, 2'b10, 32'hDEAD, 0);
        step(1, 2'b10, 32'hBEEF, 0);
        step(1, 2'b11, 32'h0, 0);
        drain();
        async_reset();

        // Overflow with ready held low; five passes also saturate the 2-bit copy.
        for (int i = 1; i <= 5; i++) step(1, 2'b01, DW'(i), 0);
        drain();
        async_reset();

        // Push and pop together at full: no overflow.
        for (int i = 1; i <= 4; i++) step(1, 2'b01, DW'(i), 0);
        step(1, 2'b01, 32'h9, 1);
        drain();

        // Kind 00 ignored, then DONE, then reports after halt ignored.
        step(1, 2'b00, 32'h55, 0);
        step(1, 2'b01, 32'h7, 0);
        step(1, 2'b11, 32'h8, 0);
        step(1, 2'b01, 32'hA, 0);
        step(1, 2'b10, 32'hB, 0);
        // FIFO holds entries and done=1 when reset hits.
        async_reset();

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            logic [1:0] k;
            k = 2'($urandom_range(0, 3));
            if (k == 2'b11 && $urandom_range(0, 15) != 0) k = 2'($urandom_range(1, 2));
            step($urandom_range(0, 3) != 0, k, DW'($urandom_range(0, 65535)), $urandom_range(0, 1) == 1);
            if (n % 64 == 63) async_reset();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
